// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO behind the WB stage, drained over a valid/ready trace port.
// Ports: wb_* commit capture in, trace_* FWFT head out, stall_req/count/overflow_cnt status.
module commit_trace_buffer #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int AF_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_commit_valid,
  input  logic [31:0] wb_commit_pc,
  input  logic [31:0] wb_commit_instr,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_wd,
  input  logic [31:0] wb_wdata,
  input  logic        wb_LLbit_we,
  input  logic        wb_LLbit_value,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_instr,
  output logic        trace_wen,
  output logic [4:0]  trace_wnum,
  output logic [31:0] trace_wdata,
  output logic        trace_llbit_we,
  output logic        trace_llbit_value,
  output logic        stall_req,
  output logic [AW:0] count,
  output logic [15:0] overflow_cnt
);

  localparam int RW = 104;
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AF   = (AW+1)'(DEPTH - AF_MARGIN);

  logic [RW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_ovf;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_wen;
  logic [RW-1:0] w_rec;
  logic [RW-1:0] w_head;

  assign w_full = (r_count == LP_FULL);
  assign w_pop  = trace_valid && trace_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push = wb_commit_valid && (!w_full || w_pop);
  assign w_drop = wb_commit_valid && w_full && !w_pop;
  // Writes to r0 are architecturally invisible.
  assign w_wen  = wb_wreg && (wb_wd != 5'd0);

  assign w_rec = {wb_commit_pc, wb_commit_instr, w_wen, wb_wd,
                  wb_wdata, wb_LLbit_we, wb_LLbit_value};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_rec;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
      if (w_drop && (r_ovf != 16'hFFFF))
        r_ovf <= r_ovf + 16'd1;
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign trace_valid       = (r_count != '0);
  assign trace_pc          = w_head[103:72];
  assign trace_instr       = w_head[71:40];
  assign trace_wen         = w_head[39];
  assign trace_wnum        = w_head[38:34];
  assign trace_wdata       = w_head[33:2];
  assign trace_llbit_we    = w_head[1];
  assign trace_llbit_value = w_head[0];

  assign stall_req    = (r_count >= LP_AF);
  assign count        = r_count;
  assign overflow_cnt = r_ovf;

endmodule
